dff_reset_pair: RTL and testbench
=================================

DFF_RESET_PAIR -- requirements
Module: dff_reset_pair

Interface
REQ-001 Parameter WIDTH, default 1, data width of d and both outputs.
REQ-002 Parameter RST_VAL, default all-zeros (WIDTH bits), value loaded into both registers on reset.
REQ-003 clk  input  1  single clock; both registers update on the rising edge only.
REQ-004 rstn  input  1  reset, asynchronous and active-low.
REQ-005 d  input  WIDTH  data sampled by both registers on each rising clk edge.
REQ-006 q_async  output  WIDTH  registered d with asynchronous active-low clear.
REQ-007 q_sync  output  WIDTH  registered d with synchronous active-low clear.

Function
REQ-008 The block SHALL contain two independent WIDTH-bit registers that are both fed by d and clocked by clk.
REQ-009 The async register SHALL drive q_async.
REQ-010 On rstn falling to 0, q_async SHALL become RST_VAL immediately, with no clock edge required.
REQ-011 While rstn=0, q_async SHALL hold RST_VAL regardless of clk or d.
REQ-012 While rstn=1, q_async SHALL take the value of d sampled at each rising clk edge, with 1-cycle latency.
REQ-013 The sync register SHALL drive q_sync.
REQ-014 q_sync SHALL load RST_VAL only at a rising clk edge where rstn=0; otherwise it loads d.
REQ-015 Between clock edges, q_sync SHALL ignore rstn entirely.
REQ-016 A rstn pulse low that contains no rising clk edge SHALL clear q_async but SHALL leave q_sync unchanged.
REQ-017 Deassertion edge: when rstn rises, q_async SHALL resume capturing d at the first rising clk edge after rstn=1.
REQ-018 Deassertion edge: q_sync SHALL capture d at the first rising clk edge where it samples rstn=1.
REQ-019 If rstn changes coincident with a clk edge, the result is undefined; stimulus SHALL change rstn away from clk edges.
REQ-020 Changes on d between edges SHALL NOT affect either output.
REQ-021 Outputs SHALL be driven directly from flops, with no combinational path from d to either output.

Reset
REQ-022 rstn is the single reset input.
REQ-023 For q_async, rstn acts asynchronously, with reset value RST_VAL.
REQ-024 For q_sync, rstn is sampled at rising clk edges, with reset value RST_VAL.
REQ-025 Before the first rising clk edge with rstn=0, q_sync is unknown; integrators SHALL hold rstn low across at least one rising clk edge at power-up.
REQ-026 rstn deassertion SHALL NOT be synchronized internally; upstream logic provides a clean deassertion.

Structure
REQ-027 One sub-module, dff_cell, SHALL be instantiated twice: once with parameter ASYNC_RST=1 and once with ASYNC_RST=0.
REQ-028 Each dff_cell instance SHALL also carry WIDTH and RST_VAL.
REQ-029 A shared package dff_pkg SHALL hold the reset-mode constants RST_MODE_ASYNC and RST_MODE_SYNC.
REQ-030 dff_pkg SHALL also hold the default width constant.
REQ-031 No other state and no latches SHALL exist.

Verification
REQ-032 Clock period 10, first rising edge at t=5; rstn=0 over the t=5 edge, then rstn=1 at t=8 -> q_async=0 and q_sync=0 after the t=5 edge.
REQ-033 With rstn=1, drive d=1,0,1,1,0,1 with each value held one period -> both outputs equal the sequence delayed one edge, and the two outputs are identical.
REQ-034 With q_async=q_sync=1, drop rstn to 0 mid-low-phase, e.g. t=+2 after an edge -> q_async=0 immediately, q_sync stays 1 until the next rising edge, then 0.
REQ-035 With rstn=0, toggle d randomly for 6 edges -> both outputs stay 0 throughout.
REQ-036 With outputs=1, pulse rstn low for 3 time units between edges -> q_async=0 until the next edge, which recaptures d; q_sync stays 1, unaffected.
REQ-037 With WIDTH=8 and RST_VAL=8'hA5, assert rstn then release it and drive d=8'h3C -> both outputs show 8'hA5 during reset and 8'h3C one edge after release.

Source files
------------

// File: rtl/dff_pkg.sv
// Shared constants for the dff_reset_pair slice: reset-mode selectors and default width.
package dff_pkg;
  localparam bit RST_MODE_ASYNC    = 1'b1;
  localparam bit RST_MODE_SYNC     = 1'b0;
  localparam int DFF_WIDTH_DEFAULT = 1;
endpackage

// File: rtl/dff_cell.sv
// WIDTH-bit register with active-low clear; ASYNC_RST picks asynchronous or clock-sampled clear.
module dff_cell
  import dff_pkg::*;
#(
  parameter int               WIDTH     = DFF_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] RST_VAL   = '0,
  parameter bit               ASYNC_RST = RST_MODE_ASYNC
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  assign q_d = d;

  generate
    if (ASYNC_RST == RST_MODE_ASYNC) begin : g_async
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) q_q <= RST_VAL;
        else       q_q <= q_d;
      end
    end else begin : g_sync
      // rstn is only looked at on the rising edge; pulses between edges are invisible here
      always_ff @(posedge clk) begin
        if (!rstn) q_q <= RST_VAL;
        else       q_q <= q_d;
      end
    end
  endgenerate

  assign q = q_q;
endmodule

// File: rtl/dff_reset_pair.sv
// Two registers on the same d/clk/rstn: one cleared asynchronously, one cleared at the clock edge.
module dff_reset_pair
  import dff_pkg::*;
#(
  parameter int               WIDTH   = DFF_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q_async,
  output logic [WIDTH-1:0] q_sync
);
  dff_cell #(
    .WIDTH     (WIDTH),
    .RST_VAL   (RST_VAL),
    .ASYNC_RST (RST_MODE_ASYNC)
  ) u_async (
    .clk  (clk),
    .rstn (rstn),
    .d    (d),
    .q    (q_async)
  );

  dff_cell #(
    .WIDTH     (WIDTH),
    .RST_VAL   (RST_VAL),
    .ASYNC_RST (RST_MODE_SYNC)
  ) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (d),
    .q    (q_sync)
  );
endmodule

// File: tb/tb_dff_reset_pair.sv
// Random + directed bench for dff_reset_pair: a 1-bit zero-reset instance and an 8-bit 8'hA5-reset instance.
module tb_dff_reset_pair;
  localparam logic [7:0] WRST = 8'hA5;

  logic       clk = 1'b0;
  logic       rstn;
  logic       d;
  logic [7:0] dw;
  logic       qa, qs;
  logic [7:0] qwa, qws;

  // expected outputs, tracked from the reset/capture rules
  logic       ea, es;
  logic [7:0] ewa, ews;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dff_reset_pair u_dut1 (
    .clk     (clk),
    .rstn    (rstn),
    .d       (d),
    .q_async (qa),
    .q_sync  (qs)
  );

  dff_reset_pair #(.WIDTH(8), .RST_VAL(WRST)) u_dut8 (
    .clk     (clk),
    .rstn    (rstn),
    .d       (dw),
    .q_async (qwa),
    .q_sync  (qws)
  );

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t act=%h exp=%h", tag, $time, act, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".qa"},  {7'd0, qa}, {7'd0, ea});
    chk({tag, ".qs"},  {7'd0, qs}, {7'd0, es});
    chk({tag, ".qwa"}, qwa, ewa);
    chk({tag, ".qws"}, qws, ews);
  endtask

  // Samples the inputs just before the edge, lets the edge happen, checks at edge+1.
  task automatic edge_step(input string tag);
    logic       r, dv;
    logic [7:0] dwv;
    r = rstn; dv = d; dwv = dw;
    @(posedge clk);
    if (!r) begin
      ea = 1'b0; es = 1'b0; ewa = WRST; ews = WRST;
    end else begin
      ea = dv; es = dv; ewa = dwv; ews = dwv;
    end
    #1;
    chk_all(tag);
  endtask

  // Falling rstn clears only the async side at once; the sync side waits for an edge.
  task automatic drop_rstn(input string tag);
    rstn = 1'b0;
    ea = 1'b0; ewa = WRST;
    #1;
    chk_all(tag);
  endtask

  initial begin
    logic [5:0] seq;
    seq  = 6'b101101;
    rstn = 1'b0;
    d    = 1'($urandom);
    dw   = 8'($urandom);

    // reset held across the t=5 edge, released at t=8
    edge_step("por");
    #2 rstn = 1'b1;
    #1 chk_all("por_rel");

    // d = 1,0,1,1,0,1 ; wide side released into 8'h3C first
    dw = 8'h3C;
    for (int i = 0; i < 6; i++) begin
      d = seq[5-i];
      edge_step("seq");
      chk("seq.same", {7'd0, qa}, {7'd0, qs});
      dw = 8'($urandom);
    end

    // outputs are 1 here; drop rstn 2 units after an edge and hold it
    #1 drop_rstn("drop");
    edge_step("drop_edge");
    for (int i = 0; i < 6; i++) begin
      d = 1'($urandom); dw = 8'($urandom);
      edge_step("held");
    end

    // release, load ones, then a 3-unit pulse with no edge inside
    #1 rstn = 1'b1;
    d = 1'b1; dw = 8'hFF;
    edge_step("load1");
    edge_step("load1b");
    drop_rstn("pulse");
    #2 rstn = 1'b1;
    #1 chk_all("pulse_rel");
    edge_step("pulse_edge");

    // randomized mix of captures, held resets, short pulses and mid-cycle d changes
    for (int i = 0; i < 150; i++) begin
      int op;
      d  = 1'($urandom);
      dw = 8'($urandom);
      op = int'($urandom_range(0, 5));
      case (op)
        0: begin
          if (rstn) begin
            drop_rstn("r_pulse");
            #1 rstn = 1'b1;
            #1 chk_all("r_pulse_rel");
          end
        end
        1: begin
          if (rstn) drop_rstn("r_hold");
          else begin
            rstn = 1'b1;
            #1 chk_all("r_rel");
          end
        end
        2: begin
          #2 d = ~d; dw = 8'($urandom);
          #1 chk_all("r_dmid");
        end
        default: ;
      endcase
      edge_step("r_edge");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
